mmc_cmd_tx: RTL and testbench



---
 rtl/mmc_cmd_tx.sv | 185 ++++++++++++++++++
 tb/tb_mmc_cmd_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_cmd_tx.sv
// mmc_cmd_tx: transmit side of the MMC/SD CMD line.
// Serialises one 48-bit command frame (start, transmission, index, argument, CRC7, end)
// MSB first onto a divided MMC clock. The CMD line changes only when mmc_clk_o falls,
// so the card samples it on the rising edge.
// Optional build macro MMC_CMD_TX_GAP_EN: after each frame, hold the line idle for
// GAP_CLKS mmc_clk_o periods (N_CC) before accepting the next command.
module mmc_cmd_tx #(
   parameter int unsigned CLK_DIV  = 2,  // half-period of mmc_clk_o in clk cycles, 1..255
   parameter int unsigned GAP_CLKS = 8   // idle mmc_clk_o periods after a frame (gap build only)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_trans,
   input  logic [5:0]  cmd_index,
   input  logic [31:0] cmd_arg,
   output logic        busy,
   output logic        done,
   output logic        mmc_clk_o,
   output logic        mmc_cmd_o,
   output logic        mmc_cmd_oe
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StArm   = 2'd1;
   localparam logic [1:0] StShift = 2'd2;
`ifdef MMC_CMD_TX_GAP_EN
   localparam logic [1:0] StGap   = 2'd3;
   localparam logic [7:0] GapLast = 8'(GAP_CLKS - 1);
`endif
   localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

   logic [1:0]  state_q, state_d;
   logic [7:0]  div_cnt_q, div_cnt_d;
   logic        mmc_clk_q, mmc_clk_d;
   logic [47:0] shreg_q, shreg_d;
   logic [5:0]  bitcnt_q, bitcnt_d;
   logic        cmd_q, cmd_d;
   logic        oe_q, oe_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        fall_evt;
   logic [39:0] hdr;
`ifdef MMC_CMD_TX_GAP_EN
   logic [7:0]  gap_cnt_q, gap_cnt_d;
`endif

   // CRC7, polynomial x^7 + x^3 + 1, zero initial value, MSB first
   function automatic logic [6:0] crc7(input logic [39:0] data);
      logic [6:0] c;
      logic       fb;
      c = 7'd0;
      for (int i = 39; i >= 0; i--) begin
         fb = c[6] ^ data[i];
         c  = {c[5:0], 1'b0};
         if (fb) c = c ^ 7'h09;
      end
      return c;
   endfunction

   assign hdr = {1'b0, cmd_trans, cmd_index, cmd_arg};

   // Free-running clock divider; fall_evt marks the cycle mmc_clk_o is registered 1->0
   always_comb begin
      fall_evt  = (div_cnt_q == DivLast) && mmc_clk_q;
      div_cnt_d = div_cnt_q + 8'd1;
      mmc_clk_d = mmc_clk_q;
      if (div_cnt_q == DivLast) begin
         div_cnt_d = 8'd0;
         mmc_clk_d = ~mmc_clk_q;
      end
   end

   // Frame sequencing: accept, align to a falling edge, shift 48 bits, release the line
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      cmd_d    = cmd_q;
      oe_d     = oe_q;
      ready_d  = ready_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
`ifdef MMC_CMD_TX_GAP_EN
      gap_cnt_d = gap_cnt_q;
`endif
      case (state_q)
         StIdle: begin
            ready_d = 1'b1;
            if (cmd_valid && ready_q) begin
               shreg_d = {hdr, crc7(hdr), 1'b1};
               ready_d = 1'b0;
               busy_d  = 1'b1;
               state_d = StArm;
            end
         end
         StArm: begin
            if (fall_evt) begin
               oe_d     = 1'b1;
               cmd_d    = shreg_q[47];
               shreg_d  = {shreg_q[46:0], 1'b0};
               bitcnt_d = 6'd47;
               state_d  = StShift;
            end
         end
         StShift: begin
            if (fall_evt) begin
               if (bitcnt_q == 6'd0) begin
                  // End bit has been held a full period: release the line
                  oe_d   = 1'b0;
                  cmd_d  = 1'b1;
                  done_d = 1'b1;
`ifdef MMC_CMD_TX_GAP_EN
                  gap_cnt_d = 8'd0;
                  state_d   = StGap;
`else
                  busy_d  = 1'b0;
                  state_d = StIdle;
`endif
               end else begin
                  cmd_d    = shreg_q[47];
                  shreg_d  = {shreg_q[46:0], 1'b0};
                  bitcnt_d = bitcnt_q - 6'd1;
               end
            end
         end
`ifdef MMC_CMD_TX_GAP_EN
         StGap: begin
            if (fall_evt) begin
               if (gap_cnt_q == GapLast) begin
                  busy_d  = 1'b0;
                  state_d = StIdle;
               end else begin
                  gap_cnt_d = gap_cnt_q + 8'd1;
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         div_cnt_q <= 8'd0;
         mmc_clk_q <= 1'b0;
         shreg_q   <= 48'd0;
         bitcnt_q  <= 6'd0;
         cmd_q     <= 1'b1;
         oe_q      <= 1'b0;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef MMC_CMD_TX_GAP_EN
         gap_cnt_q <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         div_cnt_q <= div_cnt_d;
         mmc_clk_q <= mmc_clk_d;
         shreg_q   <= shreg_d;
         bitcnt_q  <= bitcnt_d;
         cmd_q     <= cmd_d;
         oe_q      <= oe_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef MMC_CMD_TX_GAP_EN
         gap_cnt_q <= gap_cnt_d;
`endif
      end
   end

   assign cmd_ready  = ready_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign mmc_clk_o  = mmc_clk_q;
   assign mmc_cmd_o  = cmd_q;
   assign mmc_cmd_oe = oe_q;

endmodule

// File: tb/tb_mmc_cmd_tx.sv
// tb_mmc_cmd_tx: directed bench for mmc_cmd_tx.
// Instance 0 runs with CLK_DIV=2, instance 1 with CLK_DIV=1; both share clk.
module tb_mmc_cmd_tx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [2];
   logic        valid [2];
   logic        trans [2];
   logic [5:0]  idx   [2];
   logic [31:0] arg   [2];
   logic        ready [2];
   logic        busy  [2];
   logic        done  [2];
   logic        mclk  [2];
   logic        mcmd  [2];
   logic        moe   [2];

   int checks = 0;
   int errors = 0;

   // Known-good frames: CMD0 arg 0, CMD8 arg 0x1AA, CMD17 arg 0
   localparam logic [47:0] FrmCmd0  = 48'h40_0000_0000_95;
   localparam logic [47:0] FrmCmd8  = 48'h48_0000_01AA_87;
   localparam logic [47:0] FrmCmd17 = 48'h51_0000_0000_55;

   // Negedges from the done pulse until cmd_ready is seen high
`ifdef MMC_CMD_TX_GAP_EN
   localparam int Lag0 = 33;
   localparam int Lag1 = 17;
`else
   localparam int Lag0 = 1;
   localparam int Lag1 = 1;
`endif

   mmc_cmd_tx #(.CLK_DIV(2), .GAP_CLKS(8)) u_dut_div2 (
      .clk(clk), .reset_n(rst_n[0]), .cmd_valid(valid[0]), .cmd_ready(ready[0]),
      .cmd_trans(trans[0]), .cmd_index(idx[0]), .cmd_arg(arg[0]), .busy(busy[0]),
      .done(done[0]), .mmc_clk_o(mclk[0]), .mmc_cmd_o(mcmd[0]), .mmc_cmd_oe(moe[0])
   );

   mmc_cmd_tx #(.CLK_DIV(1), .GAP_CLKS(8)) u_dut_div1 (
      .clk(clk), .reset_n(rst_n[1]), .cmd_valid(valid[1]), .cmd_ready(ready[1]),
      .cmd_trans(trans[1]), .cmd_index(idx[1]), .cmd_arg(arg[1]), .busy(busy[1]),
      .done(done[1]), .mmc_clk_o(mclk[1]), .mmc_cmd_o(mcmd[1]), .mmc_cmd_oe(moe[1])
   );

   // mmc_clk period watcher for the CLK_DIV=1 instance (rise-to-rise must be 2 clk)
   int   per_cnt = 0;
   int   per_bad = 0;
   bit   per_arm = 1'b0;
   bit   per_en  = 1'b0;
   logic mclk1_prev = 1'b0;
   always @(negedge clk) begin
      if (per_en) begin
         per_cnt <= per_cnt + 1;
         if (mclk[1] && !mclk1_prev) begin
            if (per_arm && per_cnt != 1) per_bad <= per_bad + 1;
            per_arm <= 1'b1;
            per_cnt <= 0;
         end
      end
      mclk1_prev <= mclk[1];
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present a command, wait for cmd_ready, and return just after the accept edge
   task automatic accept(input int d, input logic t, input logic [5:0] ix, input logic [31:0] a,
                         input bit hold, output int waited);
      @(negedge clk);
      trans[d] = t;
      idx[d]   = ix;
      arg[d]   = a;
      valid[d] = 1'b1;
      waited   = 1;
      while (!ready[d] && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("accept_ready", 64'(ready[d]), 64'd1);
      @(posedge clk);
      #1;
      chk("ready_drop", 64'(ready[d]), 64'd0);
      chk("busy_rise", 64'(busy[d]), 64'd1);
      if (!hold) valid[d] = 1'b0;
   endtask

   // Sample the CMD line on mmc_clk rising edges until done (or abort with reset)
   task automatic capture(input int d, input bit disturb, input int abort_at,
                          output logic [47:0] cap, output int nbits, output int oe_cyc,
                          output int dones, output int lat);
      logic prev;
      int   limit;
      cap    = '0;
      nbits  = 0;
      oe_cyc = 0;
      dones  = 0;
      lat    = -1;
      limit  = (d == 0) ? 500 : 300;
      prev   = mclk[d];
      for (int i = 1; i <= limit; i++) begin
         @(negedge clk);
         if (moe[d]) begin
            oe_cyc++;
            if (lat < 0) lat = i - 1;
         end
         if (mclk[d] && !prev && moe[d]) begin
            cap = {cap[46:0], mcmd[d]};
            nbits++;
         end
         prev = mclk[d];
         if (done[d]) begin
            dones++;
            break;
         end
         if (abort_at > 0 && nbits == abort_at) begin
            rst_n[d] = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("rst_oe", 64'(moe[d]), 64'd0);
            chk("rst_cmd", 64'(mcmd[d]), 64'd1);
            chk("rst_clk", 64'(mclk[d]), 64'd0);
            chk("rst_ready", 64'(ready[d]), 64'd0);
            chk("rst_busy", 64'(busy[d]), 64'd0);
            rst_n[d] = 1'b1;
            for (int k = 0; k < 600; k++) begin
               @(negedge clk);
               if (done[d]) dones++;
            end
            break;
         end
         if (disturb) begin
            valid[d] = busy[d] && i[0];
            arg[d]   = 32'hDEAD_0000 + 32'(i);
         end
      end
   endtask

   // Count negedges until cmd_ready returns; the line must idle high with oe low meanwhile
   task automatic ready_lag(input int d, output int lag, output int idle_bad);
      lag      = 0;
      idle_bad = 0;
      do begin
         @(negedge clk);
         lag++;
         if (moe[d] || !mcmd[d]) idle_bad++;
      end while (!ready[d] && lag < 100);
   endtask

   logic [47:0] cap;
   logic [3:0]  pat;
   int          nb, oec, dn, lat, w, lag, bad, extra;

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_n[d] = 1'b0;
         valid[d] = 1'b0;
         trans[d] = 1'b0;
         idx[d]   = 6'd0;
         arg[d]   = 32'd0;
      end
      repeat (3) @(negedge clk);
      chk("rst_state_ready", 64'(ready[0]), 64'd0);
      chk("rst_state_busy", 64'(busy[0]), 64'd0);
      chk("rst_state_done", 64'(done[0]), 64'd0);
      chk("rst_state_clk", 64'(mclk[0]), 64'd0);
      chk("rst_state_cmd", 64'(mcmd[0]), 64'd1);
      chk("rst_state_oe", 64'(moe[0]), 64'd0);

      // Release reset; divider for CLK_DIV=2 gives 0,1,1,0 over the first four cycles
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      pat = '0;
      @(negedge clk);
      chk("ready_after_release", 64'(ready[0]), 64'd1);
      pat = {pat[2:0], mclk[0]};
      repeat (3) begin
         @(negedge clk);
         pat = {pat[2:0], mclk[0]};
      end
      chk("div_pattern", 64'(pat), 64'h6);
      per_en = 1'b1;

      // CMD0, arg 0
      accept(0, 1'b1, 6'd0, 32'h0, 1'b0, w);
      capture(0, 1'b0, 0, cap, nb, oec, dn, lat);
      chk("cmd0_frame", 64'(cap), 64'(FrmCmd0));
      chk("cmd0_bits", 64'(nb), 64'd48);
      chk("cmd0_oe_cycles", 64'(oec), 64'd192);
      chk("cmd0_done", 64'(dn), 64'd1);
      chk("cmd0_latency_in_range", 64'((lat >= 1 && lat <= 4) ? 1 : 0), 64'd1);
      ready_lag(0, lag, bad);
      chk("cmd0_ready_lag", 64'(lag), 64'(Lag0));
      chk("cmd0_idle_line", 64'(bad), 64'd0);

      // CMD8, arg 0x1AA
      accept(0, 1'b1, 6'd8, 32'h0000_01AA, 1'b0, w);
      capture(0, 1'b0, 0, cap, nb, oec, dn, lat);
      chk("cmd8_frame", 64'(cap), 64'(FrmCmd8));
      chk("cmd8_done", 64'(dn), 64'd1);
      ready_lag(0, lag, bad);

      // CMD17, arg 0
      accept(0, 1'b1, 6'd17, 32'h0, 1'b0, w);
      capture(0, 1'b0, 0, cap, nb, oec, dn, lat);
      chk("cmd17_frame", 64'(cap), 64'(FrmCmd17));
      chk("cmd17_done", 64'(dn), 64'd1);
      ready_lag(0, lag, bad);

      // CLK_DIV=1 back-to-back: cmd_valid held high, second frame queued behind the first
      accept(1, 1'b1, 6'd8, 32'h0000_01AA, 1'b1, w);
      trans[1] = 1'b1;
      idx[1]   = 6'd17;
      arg[1]   = 32'h0;
      capture(1, 1'b0, 0, cap, nb, oec, dn, lat);
      chk("b2b_first_frame", 64'(cap), 64'(FrmCmd8));
      chk("b2b_first_oe_cycles", 64'(oec), 64'd96);
      chk("b2b_first_done", 64'(dn), 64'd1);
      accept(1, 1'b1, 6'd17, 32'h0, 1'b0, w);
      chk("b2b_accept_lag", 64'(w), 64'(Lag1));
      capture(1, 1'b0, 0, cap, nb, oec, dn, lat);
      chk("b2b_second_frame", 64'(cap), 64'(FrmCmd17));
      chk("b2b_second_done", 64'(dn), 64'd1);
      chk("b2b_clk_period", 64'(per_bad), 64'd0);

      // Reset pulse at bit 20 abandons the frame; a fresh frame follows cleanly
      accept(0, 1'b1, 6'd0, 32'h0, 1'b0, w);
      capture(0, 1'b0, 20, cap, nb, oec, dn, lat);
      chk("abort_bits", 64'(nb), 64'd20);
      chk("abort_no_done", 64'(dn), 64'd0);
      accept(0, 1'b1, 6'd17, 32'h0, 1'b0, w);
      capture(0, 1'b0, 0, cap, nb, oec, dn, lat);
      chk("post_abort_frame", 64'(cap), 64'(FrmCmd17));
      chk("post_abort_done", 64'(dn), 64'd1);
      ready_lag(0, lag, bad);

      // cmd_valid toggling and cmd_arg changing while busy must not disturb the frame
      accept(0, 1'b1, 6'd8, 32'h0000_01AA, 1'b0, w);
      capture(0, 1'b1, 0, cap, nb, oec, dn, lat);
      valid[0] = 1'b0;
      chk("busy_ignore_frame", 64'(cap), 64'(FrmCmd8));
      chk("busy_ignore_done", 64'(dn), 64'd1);
      ready_lag(0, lag, bad);
      extra = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (moe[0] || !ready[0]) extra++;
      end
      chk("no_extra_frame", 64'(extra), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
